// File: rtl/ifmap_rearrange.sv
`default_nettype none
// ============================================================================
// ifmap_rearrange : streams one CNN ifmap as oH*oH im2col columns of C*wH*wH
//                   elements. IFMAP_REARRANGE_STATS_EN adds a stall counter.
// Revision        : 1.0
// ============================================================================
module ifmap_rearrange #(
    parameter int C  = 3,
    parameter int iH = 8,
    parameter int wH = 3,
    parameter int P  = 1,
    parameter int S  = 1,
    parameter int BW = 16,
    localparam int oH     = (iH - wH + 2*P)/S + 1,
    localparam int COLLEN = C*wH*wH,
    localparam int AW     = $clog2(C*iH*iH),
    localparam int PW     = (oH*oH > 1) ? $clog2(oH*oH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [BW-1:0] rd_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [BW-1:0] out_data,
    output logic          out_last,
    output logic [PW-1:0] out_col
`ifdef IFMAP_REARRANGE_STATS_EN
    ,
    output logic [31:0]   stall_cnt
`endif
);

    localparam int KW = (wH > 1) ? $clog2(wH) : 1;
    localparam int CW = (C > 1) ? $clog2(C) : 1;
    localparam int OW = (oH > 1) ? $clog2(oH) : 1;
    localparam int SW = AW + 2;
    localparam int IW = $clog2(COLLEN) + 1;
    localparam logic signed [SW-1:0] IHS = SW'(iH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [KW-1:0] kc_q, kr_q;
    logic [CW-1:0] c_q;
    logic [OW-1:0] ocol_q, orow_q;

    logic          inflight_q, infl_last_q;
    logic [PW-1:0] infl_col_q;
    logic [BW-1:0] fdata_q [2];
    logic [1:0]    flast_q;
    logic [PW-1:0] fcol_q [2];
    logic          wptr_q, rptr_q;
    logic [1:0]    count_q;

    logic signed [SW-1:0] w_ir, w_ic;
    logic [2:0]           w_occ;
    logic [PW-1:0]        w_col;
    logic w_pad, w_elast, w_glast, w_pop, w_room, w_gen, w_rd, w_padpush;
    logic kc_wrap, kr_wrap, c_wrap, ocol_wrap, orow_wrap;

    assign kc_wrap   = (kc_q == KW'(wH-1));
    assign kr_wrap   = (kr_q == KW'(wH-1));
    assign c_wrap    = (c_q == CW'(C-1));
    assign ocol_wrap = (ocol_q == OW'(oH-1));
    assign orow_wrap = (orow_q == OW'(oH-1));

    assign w_ir  = SW'(orow_q)*SW'(S) + SW'(kr_q) - SW'(P);
    assign w_ic  = SW'(ocol_q)*SW'(S) + SW'(kc_q) - SW'(P);
    assign w_pad = w_ir[SW-1] | w_ic[SW-1] | (w_ir >= IHS) | (w_ic >= IHS);

    assign w_elast = ((IW'(c_q)*IW'(wH*wH) + IW'(kr_q)*IW'(wH) + IW'(kc_q)) == IW'(COLLEN-1));
    assign w_glast = w_elast && ocol_wrap && orow_wrap;
    assign w_col   = PW'(SW'(orow_q)*SW'(oH) + SW'(ocol_q));

    // Occupancy counts the in-flight read so a returning word always has a slot.
    assign w_pop     = out_valid && out_ready;
    assign w_occ     = 3'(count_q) + 3'(inflight_q) - 3'(w_pop);
    assign w_room    = (w_occ < 3'd2);
    assign w_gen     = !rst && w_room && ((state_q == S_IDLE && start) || state_q == S_RUN);
    assign w_rd      = w_gen && !w_pad;
    assign w_padpush = w_gen && w_pad;

    assign rd_en   = w_rd;
    assign rd_addr = w_rd ? AW'(SW'(c_q)*SW'(iH*iH) + w_ir*IHS + w_ic) : '0;

    assign out_valid = (count_q != 2'd0);
    assign out_data  = fdata_q[rptr_q];
    assign out_last  = flast_q[rptr_q];
    assign out_col   = fcol_q[rptr_q];

    assign busy = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done = (state_q == S_DONE);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = w_glast ? S_DRAIN : S_RUN;
            S_RUN:   if (w_gen && w_glast) state_d = S_DRAIN;
            S_DRAIN: if (count_q == 2'd0 && !inflight_q) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            kc_q   <= '0;
            kr_q   <= '0;
            c_q    <= '0;
            ocol_q <= '0;
            orow_q <= '0;
        end else if (w_gen) begin
            kc_q <= kc_wrap ? '0 : kc_q + 1'b1;
            if (kc_wrap) begin
                kr_q <= kr_wrap ? '0 : kr_q + 1'b1;
                if (kr_wrap) begin
                    c_q <= c_wrap ? '0 : c_q + 1'b1;
                    if (c_wrap) begin
                        ocol_q <= ocol_wrap ? '0 : ocol_q + 1'b1;
                        if (ocol_wrap) orow_q <= orow_wrap ? '0 : orow_q + 1'b1;
                    end
                end
            end
        end
    end

    // A returning read is older than a pad generated in the same cycle, so it
    // takes the lower slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                fdata_q[i] <= '0;
                fcol_q[i]  <= '0;
            end
            flast_q     <= '0;
            wptr_q      <= 1'b0;
            rptr_q      <= 1'b0;
            count_q     <= '0;
            inflight_q  <= 1'b0;
            infl_last_q <= 1'b0;
            infl_col_q  <= '0;
        end else begin
            if (inflight_q) begin
                fdata_q[wptr_q] <= rd_data;
                flast_q[wptr_q] <= infl_last_q;
                fcol_q[wptr_q]  <= infl_col_q;
            end
            if (w_padpush) begin
                fdata_q[wptr_q ^ inflight_q] <= '0;
                flast_q[wptr_q ^ inflight_q] <= w_elast;
                fcol_q[wptr_q ^ inflight_q]  <= w_col;
            end
            wptr_q      <= wptr_q ^ inflight_q ^ w_padpush;
            rptr_q      <= rptr_q ^ w_pop;
            count_q     <= count_q + {1'b0, inflight_q} + {1'b0, w_padpush} - {1'b0, w_pop};
            inflight_q  <= w_rd;
            infl_last_q <= w_elast;
            infl_col_q  <= w_col;
        end
    end

`ifdef IFMAP_REARRANGE_STATS_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt_q <= '0;
        else if (state_q == S_IDLE && start)
            stall_cnt_q <= '0;
        else if (out_valid && !out_ready && stall_cnt_q != '1)
            stall_cnt_q <= stall_cnt_q + 32'd1;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ifmap_rearrange.sv
`default_nettype none
// ============================================================================
// tb_ifmap_rearrange : randomized bench for ifmap_rearrange, two geometries.
// Revision           : 1.0
// ============================================================================
module tb_ifmap_rearrange;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Instance A: C=1 iH=3 wH=3 P=1 S=1 ; Instance B: C=2 iH=4 wH=2 P=0 S=2
    logic        start_a = 1'b0, out_ready_a = 1'b0;
    logic        busy_a, done_a, rd_en_a, out_valid_a, out_last_a;
    logic [3:0]  rd_addr_a, out_col_a;
    logic [15:0] rd_data_a = '0, out_data_a;

    logic        start_b = 1'b0, out_ready_b = 1'b0;
    logic        busy_b, done_b, rd_en_b, out_valid_b, out_last_b;
    logic [4:0]  rd_addr_b;
    logic [1:0]  out_col_b;
    logic [15:0] rd_data_b = '0, out_data_b;

`ifdef IFMAP_REARRANGE_STATS_EN
    logic [31:0] stall_cnt_a, stall_cnt_b;
`endif

    ifmap_rearrange #(.C(1), .iH(3), .wH(3), .P(1), .S(1), .BW(16)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
        .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
        .out_last(out_last_a), .out_col(out_col_a)
`ifdef IFMAP_REARRANGE_STATS_EN
        , .stall_cnt(stall_cnt_a)
`endif
    );

    ifmap_rearrange #(.C(2), .iH(4), .wH(2), .P(0), .S(2), .BW(16)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
        .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
        .out_last(out_last_b), .out_col(out_col_b)
`ifdef IFMAP_REARRANGE_STATS_EN
        , .stall_cnt(stall_cnt_b)
`endif
    );

    int mem_a [9];
    int mem_b [32];

    // One-cycle read memory; junk when not strobed so stray captures show up.
    always @(posedge clk) begin
        rd_data_a <= rd_en_a ? 16'(mem_a[rd_addr_a]) : 16'($urandom);
        rd_data_b <= rd_en_b ? 16'(mem_b[rd_addr_b]) : 16'($urandom);
    end

    int exp_d_a[$], exp_l_a[$], exp_c_a[$];
    int exp_d_b[$], exp_l_b[$], exp_c_b[$];
    int acc[2], done_cnt[2], rdcnt[2], stall[2];
    bit held[2];
    int hd[2], hl[2], hc[2];

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference im2col: columns p, then c / kr / kc, zero outside the ifmap.
    task automatic build(input bit b, output int nrd);
        int cc, ih, wh, pp, ss, oh, ir, ic, v, l;
        cc = b ? 2 : 1; ih = b ? 4 : 3; wh = b ? 2 : 3; pp = b ? 0 : 1; ss = b ? 2 : 1;
        oh = (ih - wh + 2*pp)/ss + 1;
        nrd = 0;
        for (int orow = 0; orow < oh; orow++)
            for (int ocol = 0; ocol < oh; ocol++)
                for (int ch = 0; ch < cc; ch++)
                    for (int kr = 0; kr < wh; kr++)
                        for (int kc = 0; kc < wh; kc++) begin
                            ir = orow*ss + kr - pp;
                            ic = ocol*ss + kc - pp;
                            if (ir < 0 || ir >= ih || ic < 0 || ic >= ih) v = 0;
                            else begin
                                v = b ? mem_b[ch*ih*ih + ir*ih + ic] : mem_a[ch*ih*ih + ir*ih + ic];
                                nrd++;
                            end
                            l = (ch*wh*wh + kr*wh + kc == cc*wh*wh - 1) ? 1 : 0;
                            if (b) begin exp_d_b.push_back(v); exp_l_b.push_back(l); exp_c_b.push_back(orow*oh + ocol); end
                            else   begin exp_d_a.push_back(v); exp_l_a.push_back(l); exp_c_a.push_back(orow*oh + ocol); end
                        end
    endtask

    task automatic observe(input bit b, input logic v, input logic rdy, input int d,
                           input logic l, input int cl, input logic dn, input logic re, input int ra);
        string pre;
        int qs, ed, el, ec;
        pre = b ? "b" : "a";
        if (re) begin
            rdcnt[b]++;
            if (b) check("b_rd_addr_in_range", (ra <= 31) ? 1 : 0, 1);
        end
        if (dn) done_cnt[b]++;
        if (v) begin
            if (held[b]) begin
                check({pre, "_hold_data"}, d, hd[b]);
                check({pre, "_hold_last"}, l, hl[b]);
                check({pre, "_hold_col"}, cl, hc[b]);
            end
            if (rdy) begin
                qs = b ? exp_d_b.size() : exp_d_a.size();
                check({pre, "_elem_expected"}, (qs > 0) ? 1 : 0, 1);
                if (qs > 0) begin
                    if (b) begin ed = exp_d_b.pop_front(); el = exp_l_b.pop_front(); ec = exp_c_b.pop_front(); end
                    else   begin ed = exp_d_a.pop_front(); el = exp_l_a.pop_front(); ec = exp_c_a.pop_front(); end
                    check({pre, "_data"}, d, ed);
                    check({pre, "_last"}, l, el);
                    check({pre, "_col"}, cl, ec);
                end
                acc[b]++;
                held[b] = 1'b0;
            end else begin
                held[b] = 1'b1; hd[b] = d; hl[b] = l; hc[b] = cl;
                stall[b]++;
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            observe(1'b0, out_valid_a, out_ready_a, out_data_a, out_last_a, out_col_a, done_a, rd_en_a, rd_addr_a);
            observe(1'b1, out_valid_b, out_ready_b, out_data_b, out_last_b, out_col_b, done_b, rd_en_b, rd_addr_b);
        end
    end

    function automatic logic ready_for(input int mode, input int i, input int st);
        logic [3:0] pat;
        pat = 4'b1001;
        case (mode)
            0:       return 1'b1;
            1:       return pat[3 - (i % 4)];
            2:       return 1'($urandom_range(0, 1));
            default: return (st < 5) ? 1'b0 : 1'b1;
        endcase
    endfunction

    task automatic set_in(input bit b, input logic s, input logic r);
        if (b) begin start_b = s; out_ready_b = r; end
        else   begin start_a = s; out_ready_a = r; end
    endtask

    // mode: 0 ready high, 1 ready pattern 1,0,0,1, 2 random, 3 five stalls then high
    task automatic run(input bit b, input int mode, input logic first_valid);
        int nrd, a0, d0, r0, total, qs;
        bit got_done;
        string pre;
        pre = b ? "b" : "a";
        total = b ? 32 : 81;
        build(b, nrd);
        a0 = acc[b]; d0 = done_cnt[b]; r0 = rdcnt[b];
        @(posedge clk); #1;
        stall[b] = 0;
        set_in(b, 1'b1, ready_for(mode, 0, 0));
        @(posedge clk); #1;
        set_in(b, 1'b0, ready_for(mode, 1, stall[b]));
        check({pre, "_first_valid"}, b ? out_valid_b : out_valid_a, first_valid);
        got_done = 1'b0;
        for (int i = 2; i < 3000 && !got_done; i++) begin
            @(posedge clk); #1;
            got_done = b ? done_b : done_a;
            set_in(b, (i == 9) ? 1'b1 : 1'b0, ready_for(mode, i, stall[b]));
        end
        check({pre, "_done_seen"}, got_done, 1);
        // start coincident with done must be ignored
        set_in(b, 1'b1, 1'b1);
        @(posedge clk); #1;
        set_in(b, 1'b0, 1'b1);
        check({pre, "_busy_after_done_start"}, b ? busy_b : busy_a, 0);
        repeat (3) @(posedge clk);
        #1;
        check({pre, "_still_idle"}, b ? busy_b : busy_a, 0);
        check({pre, "_accepts"}, acc[b] - a0, total);
        check({pre, "_done_pulses"}, done_cnt[b] - d0, 1);
        check({pre, "_reads"}, rdcnt[b] - r0, nrd);
        qs = b ? exp_d_b.size() : exp_d_a.size();
        check({pre, "_queue_empty"}, qs, 0);
`ifdef IFMAP_REARRANGE_STATS_EN
        check({pre, "_stall_cnt"}, b ? stall_cnt_b : stall_cnt_a, stall[b]);
        if (mode == 3) check({pre, "_stall_cnt_5"}, b ? stall_cnt_b : stall_cnt_a, 5);
`endif
        set_in(b, 1'b0, 1'b0);
    endtask

    task automatic abort_a();
        int nrd, a0, d0;
        build(1'b0, nrd);
        a0 = acc[0]; d0 = done_cnt[0];
        @(posedge clk); #1;
        set_in(1'b0, 1'b1, 1'b1);
        @(posedge clk); #1;
        set_in(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 500 && (acc[0] - a0) < 20; i++) begin
            @(posedge clk); #1;
        end
        check("a_reached_20", acc[0] - a0, 20);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("a_abort_busy", busy_a, 0);
        check("a_abort_valid", out_valid_a, 0);
        repeat (3) @(posedge clk);
        #1;
        check("a_abort_no_done", done_cnt[0] - d0, 0);
        exp_d_a.delete(); exp_l_a.delete(); exp_c_a.delete();
        held[0] = 1'b0;
        set_in(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            acc[i] = 0; done_cnt[i] = 0; rdcnt[i] = 0; stall[i] = 0; held[i] = 1'b0;
            hd[i] = 0; hl[i] = 0; hc[i] = 0;
        end
        for (int i = 0; i < 9; i++)  mem_a[i] = i + 1;
        for (int i = 0; i < 32; i++) mem_b[i] = int'($urandom_range(1, 65535));
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_rd_en", rd_en_a, 0);
        check("rst_rd_addr", rd_addr_a, 0);
        check("rst_out_valid", out_valid_a, 0);
        check("rst_out_data", out_data_a, 0);
        check("rst_out_last", out_last_a, 0);
        check("rst_out_col", out_col_a, 0);
`ifdef IFMAP_REARRANGE_STATS_EN
        check("rst_stall_cnt", stall_cnt_a, 0);
`endif
        rst = 1'b0;
        @(posedge clk); #1;

        run(1'b0, 0, 1'b1);
        for (int i = 0; i < 9; i++) mem_a[i] = int'($urandom_range(1, 65535));
        run(1'b0, 1, 1'b1);
        run(1'b0, 2, 1'b1);
        abort_a();
        run(1'b0, 0, 1'b1);
        run(1'b0, 3, 1'b1);
        run(1'b1, 0, 1'b0);
        for (int i = 0; i < 32; i++) mem_b[i] = int'($urandom_range(1, 65535));
        run(1'b1, 2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
